// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared command encodings, default addresses and FSM states
package mem_io_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] DEF_LED_ADDR = 9'h100;
  localparam logic [8:0] DEF_SW_ADDR  = 9'h140;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  // 2'b11 is not a request; it falls through as MNONE
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for asynchronous inputs
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - CPU memory/IO bus controller for RAM, switches and LEDs
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int         RAM_LAT  = 1,
  parameter logic [8:0] LED_ADDR = DEF_LED_ADDR,
  parameter logic [8:0] SW_ADDR  = DEF_SW_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        mem_ready,
  input  logic        halt,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic [7:0]  sw_in,
  output logic [9:0]  ledr
);

  localparam logic [2:0] LAT_INIT = 3'(RAM_LAT);

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  cmd_q;
  logic [8:0]  addr_q;
  logic [7:0]  led_wdata_q;
  logic [2:0]  cnt_q;
  logic [15:0] rdata_q;
  logic [7:0]  led_q;
  logic        halt_q;
  logic        err_q;
  logic [7:0]  ram_addr_q;
  logic [15:0] ram_wdata_q;
  logic [7:0]  sw_sync;

  logic accept;
  logic is_ram;
  logic ram_wr;
  logic ram_rd;
  logic led_wr;
  logic sw_rd;
  logic unmapped;

  sync2 #(.W(8)) u_sw_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sw_in),
    .q       (sw_sync)
  );

  assign accept   = (state_q == IDLE) && is_req(mem_cmd);
  assign is_ram   = (addr_q < 9'h100);
  assign ram_wr   = (cmd_q == MWRITE) && is_ram;
  assign ram_rd   = (cmd_q == MREAD) && is_ram;
  assign led_wr   = (cmd_q == MWRITE) && (addr_q == LED_ADDR);
  assign sw_rd    = (cmd_q == MREAD) && (addr_q == SW_ADDR);
  assign unmapped = !(ram_wr || ram_rd || led_wr || sw_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = ram_rd ? WAIT : RESP;
      WAIT:    if (cnt_q <= 3'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM address/data are loaded on accept so they are already stable during ACCESS
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q       <= MNONE;
      addr_q      <= '0;
      led_wdata_q <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      led_q       <= '0;
      halt_q      <= 1'b0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      if (halt) halt_q <= 1'b1;
      if (accept) begin
        cmd_q       <= mem_cmd;
        addr_q      <= mem_addr;
        led_wdata_q <= cpu_wdata[7:0];
        if (mem_addr < 9'h100) ram_addr_q <= mem_addr[7:0];
        if ((mem_cmd == MWRITE) && (mem_addr < 9'h100)) ram_wdata_q <= cpu_wdata;
      end
      case (state_q)
        ACCESS: begin
          if (ram_rd) cnt_q <= LAT_INIT;
          if (led_wr) led_q <= led_wdata_q;
          if (sw_rd) rdata_q <= {8'h00, sw_sync};
          if (unmapped) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q <= 3'd1) rdata_q <= ram_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_ready = (state_q == RESP);
  assign cpu_rdata = mem_ready ? rdata_q : 16'h0000;
  assign ram_we    = (state_q == ACCESS) && ram_wr;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ledr      = {err_q, halt_q, led_q};

endmodule
